// File: rtl/spi_phy_arb_if.sv
// Bundle of client, PHY and grant signals shared between the two SPI clients,
// the arbiter and the PHY.
interface spi_phy_arb_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_req0;
  logic             i_req1;
  logic             o_gnt0;
  logic             o_gnt1;
  logic             i_wr0;
  logic             i_wr1;
  logic [WIDTH-1:0] i_wdata0;
  logic [WIDTH-1:0] i_wdata1;
  logic             o_bsy0;
  logic             o_bsy1;
  logic             i_rd0;
  logic             i_rd1;
  logic [WIDTH-1:0] o_rdata0;
  logic [WIDTH-1:0] o_rdata1;
  logic             o_rdy0;
  logic             o_rdy1;
  logic             o_phy_wr;
  logic [WIDTH-1:0] o_phy_wdata;
  logic             i_phy_bsy;
  logic             o_phy_rd;
  logic [WIDTH-1:0] i_phy_rdata;
  logic             i_phy_rdy;

  modport slave (
    input  i_req0, i_req1, i_wr0, i_wr1, i_wdata0, i_wdata1, i_rd0, i_rd1,
    input  i_phy_bsy, i_phy_rdata, i_phy_rdy,
    output o_gnt0, o_gnt1, o_bsy0, o_bsy1, o_rdata0, o_rdata1, o_rdy0, o_rdy1,
    output o_phy_wr, o_phy_wdata, o_phy_rd
  );

  modport master (
    output i_req0, i_req1, i_wr0, i_wr1, i_wdata0, i_wdata1, i_rd0, i_rd1,
    output i_phy_bsy, i_phy_rdata, i_phy_rdy,
    input  o_gnt0, o_gnt1, o_bsy0, o_bsy1, o_rdata0, o_rdata1, o_rdy0, o_rdy1,
    input  o_phy_wr, o_phy_wdata, o_phy_rd
  );
endinterface

// File: rtl/spi_phy_arb.sv
// Two-client round-robin arbiter for one SPI PHY. The owner is wired straight
// through to the PHY; on release the PHY is drained so no byte leaks across owners.
module spi_phy_arb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  spi_phy_arb_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN0  = 2'd1;
  localparam logic [1:0] S_OWN1  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] phy_wdata_c, rdata0_c, rdata1_c;

  // State register; last_q remembers the most recently served client.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    bus.o_gnt0      = 1'b0;
    bus.o_gnt1      = 1'b0;
    bus.o_phy_wr    = 1'b0;
    phy_wdata_c     = '0;
    bus.o_phy_rd    = 1'b0;
    bus.o_bsy0      = 1'b1;
    bus.o_bsy1      = 1'b1;
    bus.o_rdy0      = 1'b0;
    bus.o_rdy1      = 1'b0;
    rdata0_c        = '0;
    rdata1_c        = '0;

    case (state_q)
      S_IDLE: begin
        // A grant is only issued once the PHY has gone quiet.
        if (!bus.i_phy_bsy) begin
          if (bus.i_req0 && bus.i_req1) begin
            state_d = last_q ? S_OWN0 : S_OWN1;
          end else if (bus.i_req0) begin
            state_d = S_OWN0;
          end else if (bus.i_req1) begin
            state_d = S_OWN1;
          end
        end
      end

      S_OWN0: begin
        bus.o_gnt0   = 1'b1;
        bus.o_phy_wr = bus.i_wr0;
        phy_wdata_c  = bus.i_wdata0;
        bus.o_phy_rd = bus.i_rd0;
        bus.o_bsy0   = bus.i_phy_bsy;
        bus.o_rdy0   = bus.i_phy_rdy;
        rdata0_c     = bus.i_phy_rdata;
        if (!bus.i_req0) begin
          state_d = S_DRAIN;
          last_d  = 1'b0;
        end
      end

      S_OWN1: begin
        bus.o_gnt1   = 1'b1;
        bus.o_phy_wr = bus.i_wr1;
        phy_wdata_c  = bus.i_wdata1;
        bus.o_phy_rd = bus.i_rd1;
        bus.o_bsy1   = bus.i_phy_bsy;
        bus.o_rdy1   = bus.i_phy_rdy;
        rdata1_c     = bus.i_phy_rdata;
        if (!bus.i_req1) begin
          state_d = S_DRAIN;
          last_d  = 1'b1;
        end
      end

      S_DRAIN: begin
        // Keep the releasing client granted and busy; acknowledge any stale byte.
        bus.o_gnt0   = !last_q;
        bus.o_gnt1   = last_q;
        bus.o_phy_rd = bus.i_phy_rdy;
        if (!bus.i_phy_bsy && !bus.i_phy_rdy) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_phy_wdata = phy_wdata_c;
  assign bus.o_rdata0    = rdata0_c;
  assign bus.o_rdata1    = rdata1_c;

endmodule

// File: tb/tb_spi_phy_arb.sv
// Scoreboard bench for spi_phy_arb: each driven cycle pushes the expected
// output vector, a negedge monitor pops and compares it.
module tb_spi_phy_arb;

  localparam int unsigned WIDTH = 8;

  typedef enum int {M_IDLE, M_OWN0, M_OWN1, M_DR0, M_DR1} mode_e;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  sb_t  sb_q[$];

  always #5 clk = ~clk;

  spi_phy_arb_if #(.WIDTH(WIDTH)) bus();

  spi_phy_arb #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observed();
    return {bus.o_gnt0, bus.o_gnt1, bus.o_phy_wr, bus.o_phy_wdata, bus.o_phy_rd,
            bus.o_bsy0, bus.o_bsy1, bus.o_rdy0, bus.o_rdy1, bus.o_rdata0, bus.o_rdata1};
  endfunction

  // Expected outputs for a given arbiter mode and the inputs currently driven.
  function automatic logic [31:0] expected(input mode_e m);
    logic g0 = 1'b0, g1 = 1'b0, pw = 1'b0, prd = 1'b0;
    logic b0 = 1'b1, b1 = 1'b1, r0 = 1'b0, r1 = 1'b0;
    logic [7:0] pwd = 8'h00, d0 = 8'h00, d1 = 8'h00;
    case (m)
      M_OWN0: begin
        g0 = 1'b1; pw = bus.i_wr0; pwd = bus.i_wdata0; prd = bus.i_rd0;
        b0 = bus.i_phy_bsy; r0 = bus.i_phy_rdy; d0 = bus.i_phy_rdata;
      end
      M_OWN1: begin
        g1 = 1'b1; pw = bus.i_wr1; pwd = bus.i_wdata1; prd = bus.i_rd1;
        b1 = bus.i_phy_bsy; r1 = bus.i_phy_rdy; d1 = bus.i_phy_rdata;
      end
      M_DR0: begin g0 = 1'b1; prd = bus.i_phy_rdy; end
      M_DR1: begin g1 = 1'b1; prd = bus.i_phy_rdy; end
      default: ;
    endcase
    return {g0, g1, pw, pwd, prd, b0, b1, r0, r1, d0, d1};
  endfunction

  task automatic expect_mode(input string tag, input mode_e m);
    sb_t e;
    e.tag = tag;
    e.exp = expected(m);
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      chk(e.tag, observed(), e.exp);
      chk("gnt_onehot", {31'b0, bus.o_gnt0 & bus.o_gnt1}, 32'h0);
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
    bus.i_wr0 = 1'b0;  bus.i_wr1 = 1'b0;
    bus.i_rd0 = 1'b0;  bus.i_rd1 = 1'b0;
    bus.i_wdata0 = 8'h00; bus.i_wdata1 = 8'h00;
    bus.i_phy_bsy = 1'b0; bus.i_phy_rdy = 1'b0; bus.i_phy_rdata = 8'h00;
    @(posedge clk);

    cyc(); expect_mode("reset", M_IDLE);
    cyc(); rst_n = 1'b1; bus.i_req0 = 1'b1; bus.i_req1 = 1'b1; bus.i_phy_bsy = 1'b1;
    expect_mode("idle_bsy_wait0", M_IDLE);
    cyc(); expect_mode("idle_bsy_wait1", M_IDLE);
    cyc(); bus.i_phy_bsy = 1'b0; expect_mode("idle_release", M_IDLE);
    cyc(); expect_mode("tie_own0", M_OWN0);
    cyc(); bus.i_req0 = 1'b0; expect_mode("own0_drop", M_OWN0);
    cyc(); expect_mode("drain0_short", M_DR0);
    cyc(); expect_mode("idle_after_drain0", M_IDLE);
    cyc(); expect_mode("rr_own1", M_OWN1);
    cyc(); bus.i_req1 = 1'b0; expect_mode("own1_drop", M_OWN1);
    cyc(); expect_mode("drain1_short", M_DR1);
    cyc(); bus.i_req0 = 1'b1; bus.i_req1 = 1'b1; expect_mode("idle_tie2", M_IDLE);
    cyc(); expect_mode("rr_own0", M_OWN0);

    cyc(); bus.i_wr0 = 1'b1; bus.i_wdata0 = 8'h9B; expect_mode("wr0_pass", M_OWN0);
    cyc(); bus.i_wr0 = 1'b0; bus.i_wr1 = 1'b1; bus.i_wdata1 = 8'h53;
    bus.i_phy_rdy = 1'b1; bus.i_phy_rdata = 8'h74; expect_mode("iso_wr1", M_OWN0);
    cyc(); bus.i_wr1 = 1'b0; bus.i_req0 = 1'b0; expect_mode("own0_drop_rdy", M_OWN0);
    cyc(); expect_mode("flush_rd", M_DR0);
    cyc(); bus.i_phy_rdy = 1'b0; expect_mode("flush_done", M_DR0);
    cyc(); expect_mode("idle_after_flush", M_IDLE);
    cyc(); expect_mode("own1_no_stale", M_OWN1);

    cyc(); bus.i_req1 = 1'b0; bus.i_req0 = 1'b1; bus.i_phy_rdata = 8'h00;
    expect_mode("own1_drop2", M_OWN1);
    cyc(); expect_mode("drain1_b", M_DR1);
    cyc(); expect_mode("idle_b", M_IDLE);
    cyc(); expect_mode("own0_b", M_OWN0);

    cyc(); bus.i_req0 = 1'b0; bus.i_req1 = 1'b1; bus.i_phy_bsy = 1'b1;
    expect_mode("own0_drop_bsy", M_OWN0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 2) bus.i_req0 = 1'b1;
      expect_mode("drain_wait", M_DR0);
    end
    cyc(); bus.i_phy_bsy = 1'b0; expect_mode("drain_exit", M_DR0);
    cyc(); expect_mode("idle_after_wait", M_IDLE);
    cyc(); expect_mode("own1_after_wait", M_OWN1);

    cyc(); bus.i_wr1 = 1'b1; bus.i_wdata1 = 8'hA5; bus.i_rd1 = 1'b1;
    bus.i_wr0 = 1'b1; bus.i_wdata0 = 8'h3C; expect_mode("wr1_pass", M_OWN1);
    cyc(); bus.i_wr1 = 1'b0; bus.i_rd1 = 1'b0; bus.i_wr0 = 1'b0; rst_n = 1'b0;
    expect_mode("rst_assert", M_OWN1);
    cyc(); rst_n = 1'b1; expect_mode("rst_idle", M_IDLE);
    cyc(); expect_mode("rst_tie_own0", M_OWN0);

    cyc(); bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
    @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
